// File: rtl/alu16_seq.sv
// alu16_seq: runs 16-bit ADD/INC/DEC/ADD SP,e as low-byte, high-byte and an
// optional carry/borrow fix-up pass through the external 8-bit ALU.
module alu16_seq #(
  parameter int OPCODE_WIDTH = 3,
  parameter int DATA_WIDTH   = 8
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_start,
  input  logic [1:0]              i_op,
  input  logic [2*DATA_WIDTH-1:0] i_operand_A,
  input  logic [2*DATA_WIDTH-1:0] i_operand_B,
  input  logic [7:0]              i_flags_in,
  output logic                    o_busy,
  output logic                    o_done,
  output logic [2*DATA_WIDTH-1:0] o_result,
  output logic [7:0]              o_flags,
  output logic [DATA_WIDTH-1:0]   o_alu_A,
  output logic [DATA_WIDTH-1:0]   o_alu_B,
  output logic [OPCODE_WIDTH-1:0] o_alu_control,
  input  logic [DATA_WIDTH-1:0]   i_alu_data,
  input  logic [7:0]              i_alu_flags
);
  localparam int DW = DATA_WIDTH;
  localparam int W  = 2 * DATA_WIDTH;
  localparam logic [OPCODE_WIDTH-1:0] ALU_ADD = OPCODE_WIDTH'(3'b000);
  localparam logic [OPCODE_WIDTH-1:0] ALU_SUB = OPCODE_WIDTH'(3'b010);
  localparam logic [1:0] OP_ADD16 = 2'b00;
  localparam logic [1:0] OP_INC16 = 2'b01;
  localparam logic [1:0] OP_DEC16 = 2'b10;
  localparam logic [1:0] OP_ADDSP = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LO   = 3'd1,
    S_HI   = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [W-1:0]      a_q, a_d;
  logic [W-1:0]      b_q, b_d;
  logic [1:0]        op_q, op_d;
  logic [3:0]        fin_q, fin_d;
  logic [DW-1:0]     res_lo_q, res_lo_d;
  logic              c_lo_q, c_lo_d;
  logic              h_lo_q, h_lo_d;
  logic [DW-1:0]     res_hi_q, res_hi_d;
  logic              c1_q, c1_d;
  logic              h1_q, h1_d;
  logic [W-1:0]      result_q, result_d;
  logic [7:0]        flags_q, flags_d;
  logic              accept_s;
  logic              alu_h_s;
  logic              alu_c_s;
  logic [OPCODE_WIDTH-1:0] fam_s;
  logic [DW-1:0]     alu_a_s;
  logic [DW-1:0]     alu_b_s;
  logic [OPCODE_WIDTH-1:0] alu_ctl_s;
  logic              unused_s;

  assign accept_s = i_start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign alu_h_s  = i_alu_flags[5];
  assign alu_c_s  = i_alu_flags[4];
  assign unused_s = ^{i_alu_flags[7:6], i_alu_flags[3:0], i_flags_in[3:0]};

  // F byte for writeback; h_hi/c_hi are the high-byte half/full carries
  function automatic logic [7:0] flags_f(input logic [1:0] op, input logic [3:0] fin,
                                         input logic h_lo, input logic c_lo,
                                         input logic h_hi, input logic c_hi);
    case (op)
      OP_ADD16: flags_f = {fin[3], 1'b0, h_hi, c_hi, 4'b0000};
      OP_ADDSP: flags_f = {2'b00, h_lo, c_lo, 4'b0000};
      default:  flags_f = {fin, 4'b0000};
    endcase
  endfunction

  // Next-state logic and registered busy/done strobes
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (i_start) state_d = S_LO;
        else         state_d = S_IDLE;
      end
      S_LO:  state_d = S_HI;
      S_HI: begin
        if (c_lo_q) state_d = S_FIX;
        else        state_d = S_DONE;
      end
      S_FIX: state_d = S_DONE;
      S_DONE: begin
        if (i_start) state_d = S_LO;
        else         state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_LO) || (state_d == S_HI) || (state_d == S_FIX);
    done_d = (state_d == S_DONE);
  end

  // Operand capture, per-pass byte capture and result/flag assembly
  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    fin_d    = fin_q;
    res_lo_d = res_lo_q;
    c_lo_d   = c_lo_q;
    h_lo_d   = h_lo_q;
    res_hi_d = res_hi_q;
    c1_d     = c1_q;
    h1_d     = h1_q;
    result_d = result_q;
    flags_d  = flags_q;
    if (accept_s) begin
      a_d   = i_operand_A;
      op_d  = i_op;
      fin_d = i_flags_in[7:4];
      case (i_op)
        OP_ADD16: b_d = i_operand_B;
        OP_ADDSP: b_d = {{DW{i_operand_B[DW-1]}}, i_operand_B[DW-1:0]};
        default:  b_d = W'(1'b1);
      endcase
    end else begin
      a_d = a_q;
    end
    case (state_q)
      S_LO: begin
        res_lo_d = i_alu_data;
        c_lo_d   = alu_c_s;
        h_lo_d   = alu_h_s;
      end
      S_HI: begin
        res_hi_d = i_alu_data;
        c1_d     = alu_c_s;
        h1_d     = alu_h_s;
        if (!c_lo_q) begin
          result_d = {i_alu_data, res_lo_q};
          flags_d  = flags_f(op_q, fin_q, h_lo_q, c_lo_q, alu_h_s, alu_c_s);
        end else begin
          result_d = result_q;
        end
      end
      S_FIX: begin
        res_hi_d = i_alu_data;
        result_d = {i_alu_data, res_lo_q};
        flags_d  = flags_f(op_q, fin_q, h_lo_q, c_lo_q, h1_q | alu_h_s, c1_q | alu_c_s);
      end
      default: result_d = result_q;
    endcase
  end

  // ALU operand/opcode drive for the pass in progress; zero outside a pass
  always_comb begin
    if (op_q == OP_DEC16) fam_s = ALU_SUB;
    else                  fam_s = ALU_ADD;
    alu_a_s   = {DW{1'b0}};
    alu_b_s   = {DW{1'b0}};
    alu_ctl_s = ALU_ADD;
    case (state_q)
      S_LO: begin
        alu_a_s   = a_q[DW-1:0];
        alu_b_s   = b_q[DW-1:0];
        alu_ctl_s = fam_s;
      end
      S_HI: begin
        alu_a_s   = a_q[W-1:DW];
        alu_b_s   = b_q[W-1:DW];
        alu_ctl_s = fam_s;
      end
      S_FIX: begin
        alu_a_s   = res_hi_q;
        alu_b_s   = DW'(1'b1);
        alu_ctl_s = fam_s;
      end
      default: alu_ctl_s = ALU_ADD;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= S_IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      a_q      <= {W{1'b0}};
      b_q      <= {W{1'b0}};
      op_q     <= 2'b00;
      fin_q    <= 4'h0;
      res_lo_q <= {DW{1'b0}};
      c_lo_q   <= 1'b0;
      h_lo_q   <= 1'b0;
      res_hi_q <= {DW{1'b0}};
      c1_q     <= 1'b0;
      h1_q     <= 1'b0;
      result_q <= {W{1'b0}};
      flags_q  <= 8'h00;
    end else begin
      state_q  <= state_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      fin_q    <= fin_d;
      res_lo_q <= res_lo_d;
      c_lo_q   <= c_lo_d;
      h_lo_q   <= h_lo_d;
      res_hi_q <= res_hi_d;
      c1_q     <= c1_d;
      h1_q     <= h1_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  assign o_busy        = busy_q;
  assign o_done        = done_q;
  assign o_result      = result_q;
  assign o_flags       = flags_q;
  assign o_alu_A       = alu_a_s;
  assign o_alu_B       = alu_b_s;
  assign o_alu_control = alu_ctl_s;
endmodule

// File: tb/tb_alu16_seq.sv
// tb_alu16_seq: directed vectors, back-to-back/ignored-start/abort sequences and
// random operations checked against a plain 16-bit arithmetic reference.
module tb_alu16_seq;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [15:0] opa = 16'h0000;
  logic [15:0] opb = 16'h0000;
  logic [7:0]  fin = 8'h00;
  logic        busy, done;
  logic [15:0] result;
  logic [7:0]  flags;
  logic [7:0]  alu_a, alu_b, alu_data, alu_flags;
  logic [2:0]  alu_ctl;
  logic [8:0]  alu_sum;

  int n_vec = 0;
  int n_miss = 0;
  logic [15:0] prev_res = 16'h0000;
  logic [7:0]  prev_flg = 8'h00;

  typedef struct {
    logic [1:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [7:0]  fin;
    logic [15:0] res;
    logic [7:0]  flg;
    int          lat;
  } vec_t;
  vec_t tbl[10];

  always #5 clk = ~clk;

  alu16_seq dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_op(op),
    .i_operand_A(opa), .i_operand_B(opb), .i_flags_in(fin),
    .o_busy(busy), .o_done(done), .o_result(result), .o_flags(flags),
    .o_alu_A(alu_a), .o_alu_B(alu_b), .o_alu_control(alu_ctl),
    .i_alu_data(alu_data), .i_alu_flags(alu_flags)
  );

  // 8-bit ALU: H = bit 5 (nibble carry/borrow), C = bit 4 (carry/borrow)
  always_comb begin
    alu_sum   = 9'h000;
    alu_data  = 8'h00;
    alu_flags = 8'h00;
    case (alu_ctl)
      3'b000: begin
        alu_sum      = {1'b0, alu_a} + {1'b0, alu_b};
        alu_data     = alu_sum[7:0];
        alu_flags[5] = ({1'b0, alu_a[3:0]} + {1'b0, alu_b[3:0]}) > 5'h0F;
        alu_flags[4] = alu_sum[8];
      end
      3'b010: begin
        alu_data     = alu_a - alu_b;
        alu_flags[5] = alu_a[3:0] < alu_b[3:0];
        alu_flags[4] = alu_a < alu_b;
      end
      default: alu_data = 8'h00;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] beff_f(input logic [1:0] o, input logic [15:0] b);
    case (o)
      2'b00:   beff_f = b;
      2'b11:   beff_f = {{8{b[7]}}, b[7:0]};
      default: beff_f = 16'h0001;
    endcase
  endfunction

  function automatic void ref_model(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b,
                                    input logic [7:0] f, output logic [15:0] res,
                                    output logic [7:0] flg, output int lat);
    int unsigned s16, s12, s8, s4;
    res = a + beff_f(o, b);
    flg = {f[7:4], 4'h0};
    lat = 3;
    s16 = 32'(a) + 32'(b);
    s12 = 32'(a[11:0]) + 32'(b[11:0]);
    s8  = 32'(a[7:0]) + 32'(b[7:0]);
    s4  = 32'(a[3:0]) + 32'(b[3:0]);
    case (o)
      2'b00: begin
        flg = {f[7], 1'b0, s12 > 32'h0FFF, s16 > 32'hFFFF, 4'h0};
        lat = (s8 > 32'h00FF) ? 4 : 3;
      end
      2'b01: lat = (a[7:0] == 8'hFF) ? 4 : 3;
      2'b10: begin
        res = a - 16'h0001;
        lat = (a[7:0] == 8'h00) ? 4 : 3;
      end
      default: begin
        flg = {2'b00, s4 > 32'h000F, s8 > 32'h00FF, 4'h0};
        lat = (s8 > 32'h00FF) ? 4 : 3;
      end
    endcase
  endfunction

  // Called just after a negedge with the DUT in IDLE or DONE; returns at the
  // negedge of the DONE cycle so a following call starts back-to-back.
  task automatic run_op(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b,
                        input logic [7:0] f, input logic [15:0] eres, input logic [7:0] eflg,
                        input int elat, input bit glitch);
    logic [15:0] be;
    logic [2:0]  fam;
    logic [7:0]  fixa;
    int lat_obs;
    bit got, pend;
    be   = beff_f(o, b);
    fam  = (o == 2'b10) ? 3'b010 : 3'b000;
    fixa = (o == 2'b10) ? (a[15:8] - be[15:8]) : (a[15:8] + be[15:8]);
    op = o; opa = a; opb = b; fin = f; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    lat_obs = 0; got = 1'b0; pend = 1'b0;
    for (int cyc = 1; cyc <= 6 && !got; cyc++) begin
      if (pend) begin
        @(posedge clk); #1 start = 1'b0;
        pend = 1'b0;
      end
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        lat_obs = cyc;
      end else if (cyc < elat) begin
        chk("busy", busy, 1);
        chk("result_hold", result, prev_res);
        chk("flags_hold", flags, prev_flg);
        if (cyc == 1)      chk("alu_lo", {alu_a, alu_b, alu_ctl}, {a[7:0], be[7:0], fam});
        else if (cyc == 2) chk("alu_hi", {alu_a, alu_b, alu_ctl}, {a[15:8], be[15:8], fam});
        else               chk("alu_fix", {alu_a, alu_b, alu_ctl}, {fixa, 8'h01, fam});
        if (glitch && cyc == 2) begin
          start = 1'b1; opa = ~a; opb = ~b; op = ~o; fin = ~f;
          pend = 1'b1;
        end
      end
    end
    start = 1'b0;
    chk("latency", lat_obs, elat);
    if (got) begin
      chk("result", result, eres);
      chk("flags", flags, eflg);
      chk("busy_in_done", busy, 0);
    end
    prev_res = eres;
    prev_flg = eflg;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("idle_done", done, 0);
      chk("idle_busy", busy, 0);
      chk("idle_alu", {alu_a, alu_b, alu_ctl}, 19'h0);
      chk("idle_result", {result, flags}, {prev_res, prev_flg});
    end
  endtask

  initial begin
    logic [1:0]  ro;
    logic [15:0] ra, rb, eres;
    logic [7:0]  rf, eflg;
    int          elat;

    tbl[0] = '{2'b00, 16'h1234, 16'h0101, 8'h10, 16'h1335, 8'h00, 3};
    tbl[1] = '{2'b00, 16'h8FFF, 16'h0001, 8'h80, 16'h9000, 8'hA0, 4};
    tbl[2] = '{2'b00, 16'hFFFF, 16'h0001, 8'h00, 16'h0000, 8'h30, 4};
    tbl[3] = '{2'b10, 16'h0100, 16'h1234, 8'hF0, 16'h00FF, 8'hF0, 4};
    tbl[4] = '{2'b11, 16'hFFF8, 16'h5508, 8'h00, 16'h0000, 8'h30, 4};
    tbl[5] = '{2'b11, 16'h0001, 16'h00FE, 8'h00, 16'hFFFF, 8'h00, 3};
    tbl[6] = '{2'b01, 16'hFFFF, 16'hFFFF, 8'h00, 16'h0000, 8'h00, 4};
    tbl[7] = '{2'b10, 16'h0000, 16'h0000, 8'h50, 16'hFFFF, 8'h50, 4};
    tbl[8] = '{2'b01, 16'h1234, 16'h0000, 8'hB0, 16'h1235, 8'hB0, 3};
    tbl[9] = '{2'b11, 16'h0FF8, 16'h0008, 8'hF0, 16'h1000, 8'h30, 4};

    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 16'h0000);
    chk("rst_flags", flags, 8'h00);
    chk("rst_alu", {alu_a, alu_b, alu_ctl}, 19'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].fin, tbl[i].res, tbl[i].flg, tbl[i].lat, 1'b0);
      if (i % 3 == 2) idle(1);
    end

    // Back-to-back starts, with a start pulse during HI that must be ignored
    run_op(2'b00, 16'h1234, 16'h0101, 8'h10, 16'h1335, 8'h00, 3, 1'b0);
    run_op(2'b00, 16'h8FFF, 16'h0001, 8'h80, 16'h9000, 8'hA0, 4, 1'b1);
    run_op(2'b11, 16'h0001, 16'h00FE, 8'h00, 16'hFFFF, 8'h00, 3, 1'b1);
    idle(2);

    // Reset asserted while the FIX pass is in progress
    op = 2'b00; opa = 16'h8FFF; opb = 16'h0001; fin = 8'h80; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    chk("abort_in_fix", {busy, alu_b}, {1'b1, 8'h01});
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_result", result, 16'h0000);
    chk("abort_flags", flags, 8'h00);
    chk("abort_alu", {alu_a, alu_b, alu_ctl}, 19'h0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("abort_no_done", {done, busy}, 2'b00);
    end
    rst_n = 1'b1;
    prev_res = 16'h0000;
    prev_flg = 8'h00;
    run_op(2'b00, 16'h8FFF, 16'h0001, 8'h80, 16'h9000, 8'hA0, 4, 1'b0);

    for (int i = 0; i < 200; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = 16'($urandom);
      rb = 16'($urandom);
      rf = {4'($urandom), 4'h0};
      if ($urandom_range(0, 3) == 0) ra[7:0] = ($urandom_range(0, 1) == 0) ? 8'hFF : 8'h00;
      ref_model(ro, ra, rb, rf, eres, eflg, elat);
      run_op(ro, ra, rb, rf, eres, eflg, elat, $urandom_range(0, 7) == 0);
      idle($urandom_range(0, 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
